// File: rtl/riscv_pkg.sv
// Shared core definitions: core width, NOP encoding and the memory-arbiter types.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_RESP = 2'b10
    } arb_state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_s;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals around the unified memory arbiter.
interface unified_mem_arbiter_if #(parameter int XLEN = 32);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_done;
    logic [XLEN-1:0] d_rdata;
    logic            bus_err;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rvalid, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_done, d_rdata, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rvalid, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_done, d_rdata, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch and data: data wins unless fetch has waited out the streak limit.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic streak_at_max,
    output logic i_win,
    output logic d_win
);

    // data-first priority with a starvation override for fetch
    always_comb begin
        d_win = d_req & ~(i_req & streak_at_max);
        i_win = i_req & ~d_win;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports with one
// outstanding transaction, data priority, fetch anti-starvation and a read timeout.
module unified_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int MAX_D_STREAK = 4,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    unified_mem_arbiter_if.slave bus
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    arb_state_e      state_r;
    arb_src_e        src_r;
    mem_req_s        req_r;
    logic [SW-1:0]   streak_r;
    logic [TW-1:0]   tmo_r;
    logic            mem_req_r;
    logic            i_rvalid_r;
    logic [XLEN-1:0] i_rdata_r;
    logic            d_done_r;
    logic [XLEN-1:0] d_rdata_r;
    logic            bus_err_r;

    logic i_win_s;
    logic d_win_s;
    logic i_gnt_s;
    logic d_gnt_s;
    logic streak_at_max_s;

    assign streak_at_max_s = (streak_r == SW'(MAX_D_STREAK));

    mem_arb_pick u_pick (
        .i_req         (bus.i_req),
        .d_req         (bus.d_req),
        .streak_at_max (streak_at_max_s),
        .i_win         (i_win_s),
        .d_win         (d_win_s)
    );

    // grants are only offered in IDLE and are suppressed while reset is asserted
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst_n && (state_r == IDLE)) begin
            i_gnt_s = i_win_s;
            d_gnt_s = d_win_s;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // arbitration FSM, streak/timeout counters and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            src_r      <= SRC_I;
            req_r      <= '0;
            streak_r   <= '0;
            tmo_r      <= '0;
            mem_req_r  <= 1'b0;
            i_rvalid_r <= 1'b0;
            i_rdata_r  <= INSTR_NOP;
            d_done_r   <= 1'b0;
            d_rdata_r  <= '0;
            bus_err_r  <= 1'b0;
        end else begin
            i_rvalid_r <= 1'b0;
            d_done_r   <= 1'b0;
            bus_err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_gnt_s) begin
                        src_r       <= SRC_I;
                        req_r.we    <= 1'b0;
                        req_r.addr  <= word_align(bus.i_addr);
                        req_r.wdata <= '0;
                        mem_req_r   <= 1'b1;
                        streak_r    <= '0;
                        state_r     <= ISSUE;
                    end else if (d_gnt_s) begin
                        src_r       <= SRC_D;
                        req_r.we    <= bus.d_we;
                        req_r.addr  <= word_align(bus.d_addr);
                        req_r.wdata <= bus.d_wdata;
                        mem_req_r   <= 1'b1;
                        state_r     <= ISSUE;
                        if (!bus.i_req) begin
                            streak_r <= '0;
                        end else if (!streak_at_max_s) begin
                            streak_r <= streak_r + SW'(1);
                        end else begin
                            streak_r <= streak_r;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        mem_req_r <= 1'b0;
                        tmo_r     <= '0;
                        if (req_r.we) begin
                            d_done_r <= 1'b1;
                            state_r  <= IDLE;
                        end else begin
                            state_r  <= WAIT_RESP;
                        end
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT_RESP: begin
                    if (bus.mem_rvalid) begin
                        state_r <= IDLE;
                        tmo_r   <= '0;
                        if (src_r == SRC_I) begin
                            i_rvalid_r <= 1'b1;
                            i_rdata_r  <= bus.mem_rdata;
                        end else begin
                            d_done_r   <= 1'b1;
                            d_rdata_r  <= bus.mem_rdata;
                        end
                    end else if (tmo_r == TW'(RESP_TIMEOUT - 1)) begin
                        // give up on the read: respond with a harmless value and flag the error
                        state_r   <= IDLE;
                        tmo_r     <= '0;
                        bus_err_r <= 1'b1;
                        if (src_r == SRC_I) begin
                            i_rvalid_r <= 1'b1;
                            i_rdata_r  <= INSTR_NOP;
                        end else begin
                            d_done_r   <= 1'b1;
                            d_rdata_r  <= '0;
                        end
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_gnt     = i_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.i_rvalid  = i_rvalid_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_done    = d_done_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.bus_err   = bus_err_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = req_r.we;
    assign bus.mem_addr  = req_r.addr;
    assign bus.mem_wdata = req_r.wdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a small memory model answers requests and
// expected responses queued at grant time are checked when the DUT pulses a response.
module tb_unified_mem_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        ready_en = 1'b1;
    logic        drop_resp = 1'b0;
    logic        stale_rv = 1'b0;
    logic        rv_m;
    logic [31:0] rd_m;
    int          hs_cnt = 0;

    logic [31:0] mem_arr [0:255];
    logic        mem_vld [0:255];

    exp_t iq[$];
    exp_t dq[$];
    exp_t mon_e;

    unified_mem_arbiter_if #(.XLEN(32)) bus ();

    assign bus.i_req      = i_req;
    assign bus.i_addr     = i_addr;
    assign bus.d_req      = d_req;
    assign bus.d_we       = d_we;
    assign bus.d_addr     = d_addr;
    assign bus.d_wdata    = d_wdata;
    assign bus.mem_ready  = ready_en;
    assign bus.mem_rvalid = rv_m | stale_rv;
    assign bus.mem_rdata  = rd_m;

    unified_mem_arbiter #(.XLEN(32), .MAX_D_STREAK(4), .RESP_TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h0000_0104) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        return (mem_vld[idx] === 1'b1) ? mem_arr[idx] : rom(a);
    endfunction

    // one-cycle memory model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_m <= 1'b0;
            rd_m <= 32'h0;
        end else begin
            rv_m <= 1'b0;
            if (bus.mem_req && bus.mem_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (bus.mem_we) begin
                    mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
                    mem_vld[bus.mem_addr[9:2]] <= 1'b1;
                end else if (!drop_resp) begin
                    rv_m <= 1'b1;
                    rd_m <= mem_val(bus.mem_addr);
                end
            end
        end
    end

    // response monitor: pops the scoreboard on every response pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.i_rvalid) begin
                vectors++;
                if (iq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_i_rvalid got rdata=%h required no response", bus.i_rdata);
                end else begin
                    mon_e = iq.pop_front();
                    if (bus.i_rdata !== mon_e.data || bus.bus_err !== mon_e.err) begin
                        miscompares++;
                        $display("FAIL i_resp got rdata=%h err=%b required rdata=%h err=%b",
                                 bus.i_rdata, bus.bus_err, mon_e.data, mon_e.err);
                    end
                end
            end
            if (bus.d_done) begin
                vectors++;
                if (dq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_d_done got rdata=%h required no response", bus.d_rdata);
                end else begin
                    mon_e = dq.pop_front();
                    if (bus.bus_err !== mon_e.err || (mon_e.chk && bus.d_rdata !== mon_e.data)) begin
                        miscompares++;
                        $display("FAIL d_resp got rdata=%h err=%b required rdata=%h err=%b",
                                 bus.d_rdata, bus.bus_err, mon_e.data, mon_e.err);
                    end
                end
            end
            if (bus.bus_err && !bus.i_rvalid && !bus.d_done) begin
                vectors++;
                miscompares++;
                $display("FAIL lone_bus_err got bus_err=1 required 0 without a response");
            end
        end
    end

    task automatic wait_gnt(input bit is_d, output bit ok);
        int n;
        n = 0;
        while (((is_d ? bus.d_gnt : bus.i_gnt) !== 1'b1) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (n < 100);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout got no grant required grant within 100 cycles");
        end
    endtask

    task automatic issue_fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic err);
        bit ok;
        @(negedge clk);
        i_req = 1'b1;
        i_addr = a;
        #1;
        wait_gnt(1'b0, ok);
        if (ok) iq.push_back('{exp_d, err, 1'b1});
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL drain got %0d/%0d pending required 0/0", iq.size(), dq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.i_rvalid !== 1'b0 || bus.d_done !== 1'b0 ||
            bus.bus_err !== 1'b0 || bus.i_rdata !== 32'h13 || bus.d_rdata !== 32'h0 ||
            bus.mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state got req=%b irv=%b dd=%b err=%b irdata=%h drdata=%h addr=%h required 0,0,0,0,13,0,0",
                     bus.mem_req, bus.i_rvalid, bus.d_done, bus.bus_err, bus.i_rdata, bus.d_rdata, bus.mem_addr);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_fetch();
        bit ok;
        @(negedge clk);
        i_req = 1'b1;
        i_addr = 32'h0000_0104;
        #1;
        vectors++;
        if (bus.i_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_gnt_c0 got %b required 1", bus.i_gnt);
        end
        wait_gnt(1'b0, ok);
        iq.push_back('{32'h0000_0013, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_issue_c1 got req=%b addr=%h we=%b required 1,104,0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        @(negedge clk);
        vectors++;
        if (bus.i_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_early_c2 got i_rvalid=%b required 0", bus.i_rvalid);
        end
        @(negedge clk);
        vectors++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL fetch_resp_c3 got rv=%b rdata=%h required 1,00000013", bus.i_rvalid, bus.i_rdata);
        end
        drain();
    endtask

    task automatic test_store_load();
        bit ok;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            d_req = 1'b1;
            d_we = (k == 0);
            d_addr = 32'h0000_0040;
            d_wdata = (k == 0) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            wait_gnt(1'b1, ok);
            dq.push_back('{32'hDEAD_BEEF, 1'b0, (k == 1)});
            @(posedge clk);
            #1;
            d_req = 1'b0;
            @(negedge clk);
            vectors++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== (k == 0)) begin
                miscompares++;
                $display("FAIL sl_issue_%0d got req=%b addr=%h we=%b required 1,40,%0d", k, bus.mem_req, bus.mem_addr, bus.mem_we, (k == 0));
            end
            if (k == 0) begin
                @(negedge clk);
                vectors++;
                if (bus.d_done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL store_done_c2 got %b required 1", bus.d_done);
                end
            end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int got;
        got = 0;
        @(negedge clk);
        i_req = 1'b1;
        i_addr = 32'h0000_0104;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_0080;
        for (int n = 0; n < 100 && got < 6; n++) begin
            #1;
            if (bus.i_gnt === 1'b1 || bus.d_gnt === 1'b1) begin
                vectors++;
                if ((bus.i_gnt & bus.d_gnt) !== 1'b0 || bus.d_gnt !== exp_d[got]) begin
                    miscompares++;
                    $display("FAIL grant_order_%0d got i=%b d=%b required d=%b only", got, bus.i_gnt, bus.d_gnt, exp_d[got]);
                end
                if (bus.d_gnt === 1'b1) dq.push_back('{rom(32'h80), 1'b0, 1'b1});
                else iq.push_back('{32'h0000_0013, 1'b0, 1'b1});
                got++;
            end
            if (got < 6) @(negedge clk);
        end
        if (got < 6) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_count got %0d required 6", got);
        end
        @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        bit ok;
        int hs0;
        ready_en = 1'b0;
        @(negedge clk);
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_0043;
        #1;
        wait_gnt(1'b1, ok);
        dq.push_back('{32'hDEAD_BEEF, 1'b0, 1'b1});
        hs0 = hs_cnt;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stable_%0d got req=%b addr=%h we=%b required 1,40,0", c, bus.mem_req, bus.mem_addr, bus.mem_we);
            end
        end
        ready_en = 1'b1;
        drain();
        vectors++;
        if (hs_cnt - hs0 !== 1) begin
            miscompares++;
            $display("FAIL bp_handshakes got %0d required 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        issue_fetch(32'h0000_0180, rom(32'h180), 1'b0);
        drain();
        drop_resp = 1'b1;
        @(negedge clk);
        i_req = 1'b1;
        i_addr = 32'h0000_0200;
        #1;
        wait_gnt(1'b0, ok);
        iq.push_back('{32'h0000_0013, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        i_req = 1'b0;
        cnt = 0;
        while (bus.i_rvalid !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (cnt != 66 || bus.bus_err !== 1'b1 || bus.i_rdata !== 32'h13) begin
            miscompares++;
            $display("FAIL timeout got cycle=%0d err=%b rdata=%h required 66,1,00000013", cnt, bus.bus_err, bus.i_rdata);
        end
        drop_resp = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        bit ok;
        drop_resp = 1'b1;
        @(negedge clk);
        i_req = 1'b1;
        i_addr = 32'h0000_0300;
        #1;
        wait_gnt(1'b0, ok);
        @(posedge clk);
        #1;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_0040;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0 ||
            bus.i_rvalid !== 1'b0 || bus.d_done !== 1'b0 || bus.bus_err !== 1'b0 ||
            bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0 ||
            bus.i_rdata !== 32'h13 || bus.d_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset got req=%b ig=%b dg=%b irv=%b dd=%b err=%b addr=%h irdata=%h drdata=%h required all 0 irdata=13",
                     bus.mem_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_done, bus.bus_err,
                     bus.mem_addr, bus.i_rdata, bus.d_rdata);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drop_resp = 1'b0;
        @(negedge clk);
        stale_rv = 1'b1;
        @(negedge clk);
        stale_rv = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle got mem_req=%b required 0", bus.mem_req);
        end
        issue_fetch(32'h0000_0104, 32'h0000_0013, 1'b0);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_vld[i] = 1'b0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        vectors++;
        if (iq.size() != 0 || dq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover got %0d/%0d required 0/0", iq.size(), dq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage lw/sw) port.
- Arbitrates between the two, sequences a single outstanding transaction to memory, and returns responses to the originating requester.
- Sits between the IF/MEM stages and the memory model/controller.
- Data side has priority; a streak counter prevents fetch starvation; a response timeout prevents deadlock.

Parameters:
- XLEN, 32, data/address width; equals the package core width.
- MAX_D_STREAK, 4, number of consecutive data grants allowed while fetch waits; after that, fetch wins the next arbitration.
- RESP_TIMEOUT, 64, number of cycles in WAIT_RESP before a read is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  XLEN  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle (Mealy)
- i_rvalid  out  1  fetch response pulse
- i_rdata  out  XLEN  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store (sw), 0 = load (lw)
- d_addr  in  XLEN  data byte address
- d_wdata  in  XLEN  store data
- d_gnt  out  1  data request accepted this cycle (Mealy)
- d_done  out  1  data completion pulse (load data valid, or store committed)
- d_rdata  out  XLEN  load data
- bus_err  out  1  pulse together with i_rvalid/d_done when a read times out
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  XLEN  word address; bits [1:0] forced to 00
- mem_wdata  out  XLEN  memory write data
- mem_ready  in  1  memory accepts request (mem_req & mem_ready = handshake)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data

Behaviour:
- Reset:
  - All outputs are 0; i_rdata is INSTR_NOP; d_rdata is 0.
  - FSM goes to IDLE; streak and timeout counters are 0.
  - Any in-flight transaction is discarded; no response is emitted after reset releases.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE arbitration (combinational grant, latched on the clock edge):
  - Data wins if d_req, unless i_req and streak == MAX_D_STREAK; in that case fetch wins.
  - Only one of i_gnt/d_gnt is high per cycle; a grant is only ever given in IDLE.
  - The latched request goes into internal regs (source, we, addr, wdata); next state is ISSUE.
- Streak counter:
  - Increments on a d_gnt while i_req is high; saturates at MAX_D_STREAK.
  - Clears on i_gnt, or on a d_gnt with i_req low.
- ISSUE:
  - mem_req = 1, with mem_we/mem_addr/mem_wdata from the latched regs; held stable until mem_ready.
  - On handshake with a write: next state IDLE, and d_done pulses in the following cycle.
  - On handshake with a read: next state WAIT_RESP.
- WAIT_RESP:
  - mem_req = 0. On mem_rvalid, the data is registered, and the matching i_rvalid or d_done pulses one cycle later with i_rdata/d_rdata; next state IDLE.
  - Timeout counter increments each cycle here. At RESP_TIMEOUT it returns to IDLE and pulses bus_err together with the response; data returned is INSTR_NOP for fetch, 0 for data.
- mem_rvalid outside WAIT_RESP is ignored. Memory contract: no response after a timeout.
- Latency (1-cycle memory, immediate mem_ready): grant at cycle 0, mem_req at cycle 1, mem_rvalid at cycle 2, response at cycle 3. Store: d_done at cycle 2.
- The response cycle is IDLE, so a new grant may coincide with the previous response pulse.
- i_rdata/d_rdata hold their last value between responses.
- Requests that deassert before grant are dropped silently.

Decomposition:
- Add to riscv_pkg:
  - arb_state_e enum (IDLE = 2'b00, ISSUE = 2'b01, WAIT_RESP = 2'b10).
  - arb_src_e enum (SRC_I, SRC_D).
  - mem_req_s packed struct {we, addr, wdata}.
- One sub-module, mem_arb_pick: combinational priority/starvation decision (inputs i_req, d_req, streak_at_max; outputs i_win, d_win).
- FSM, counters and response regs stay in the top.

Test Plan:
- Single fetch: i_req, i_addr = 0x0000_0104, mem_rdata = 0x0000_0013 with 1-cycle latency -> i_gnt at cycle 0, mem_addr = 0x104, i_rvalid with i_rdata = 0x0000_0013 at cycle 3.
- Store then load: sw 0xDEAD_BEEF to 0x40, then lw 0x40 -> d_done at cycle 2 for the store; the load's d_done has d_rdata = 0xDEAD_BEEF; mem_addr = 0x40 for both.
- Simultaneous requests: i_req and d_req held high continuously, MAX_D_STREAK = 4 -> grant order D, D, D, D, I, D, ...; i_gnt and d_gnt never high together.
- Backpressure and alignment: mem_ready low for 5 cycles in ISSUE with d_addr = 0x43 -> mem_req/mem_addr = 0x40/mem_we stable all 5 cycles; exactly one handshake.
- Timeout: fetch read with mem_rvalid never asserted, RESP_TIMEOUT = 64 -> after 64 WAIT_RESP cycles, i_rvalid = 1, bus_err = 1, i_rdata = 0x0000_0013; FSM returns to IDLE.
- Reset mid-operation: rst_n low during WAIT_RESP -> all outputs 0 immediately; after release no i_rvalid/d_done appears; a stale mem_rvalid is ignored; the next request completes normally.
